sti_rx_pack: RTL

STI_RX_PACK -- requirements
Module: sti_rx_pack

---
 rtl/sti_rx_pack_pkg.sv | 28 ++
 rtl/sti_rx_pack_if.sv | 30 +++
 rtl/sti_rx_shifter.sv | 53 +++++
 rtl/sti_rx_pack.sv | 104 ++++++++++
 4 files changed

// File: rtl/sti_rx_pack_pkg.sv
// Shared types and constants for the STI receive packer.
// Holds the FSM encoding, field widths and the legal frame lengths.
package sti_rx_pack_pkg;

   localparam int BYTE_W = 8;
   localparam int ADDR_W = 8;
   localparam int CNT_W  = 6;

   localparam logic [CNT_W-1:0] LEN_8  = 6'd8;
   localparam logic [CNT_W-1:0] LEN_16 = 6'd16;
   localparam logic [CNT_W-1:0] LEN_24 = 6'd24;
   localparam logic [CNT_W-1:0] LEN_32 = 6'd32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   function automatic logic is_legal_len(input logic [CNT_W-1:0] n);
      return (n == LEN_8) || (n == LEN_16) || (n == LEN_24) || (n == LEN_32);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] n);
      return (n == '1) ? n : n + CNT_W'(1);
   endfunction

endpackage

// File: rtl/sti_rx_pack_if.sv
// Serial input and pixel-buffer output bundle of the STI receive packer.
// Serial side: one bit per cycle while si_valid is high; a low cycle closes the frame.
interface sti_rx_pack_if;
   import sti_rx_pack_pkg::*;

   logic              si_data;
   logic              si_valid;
   logic              lsb_first;
   logic              pixel_wr;
   logic [ADDR_W-1:0] pixel_addr;
   logic [BYTE_W-1:0] pixel_dataout;
   logic              frame_done;
   logic              frame_err;
   logic [CNT_W-1:0]  frame_bits;
   logic              buf_full;
   state_t            state;

   modport master (
      output si_data, si_valid, lsb_first,
      input  pixel_wr, pixel_addr, pixel_dataout, frame_done, frame_err,
      input  frame_bits, buf_full, state
   );

   modport slave (
      input  si_data, si_valid, lsb_first,
      output pixel_wr, pixel_addr, pixel_dataout, frame_done, frame_err,
      output frame_bits, buf_full, state
   );

endinterface

// File: rtl/sti_rx_shifter.sv
// Serial-to-byte accumulator with selectable bit order and a sub-byte counter.
// byte_ready pulses the cycle after the 8th bit lands; byte_out still holds that byte then.
module sti_rx_shifter
   import sti_rx_pack_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              shift_en,
   input  logic              clear,
   input  logic              lsb_first,
   input  logic              bit_in,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_ready
);

   logic [BYTE_W-1:0] acc;
   logic [BYTE_W-1:0] acc_next;
   logic [2:0]        sub_cnt;
   logic              lsb_q;
   logic              order;

   // The first bit of a frame uses the live lsb_first; later bits use the latched copy.
   always_comb begin
      order    = start ? lsb_first : lsb_q;
      acc_next = order ? {bit_in, acc[BYTE_W-1:1]} : {acc[BYTE_W-2:0], bit_in};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         sub_cnt    <= '0;
         lsb_q      <= 1'b0;
         byte_ready <= 1'b0;
      end else begin
         byte_ready <= 1'b0;
         if (start) begin
            lsb_q   <= lsb_first;
            acc     <= acc_next;
            sub_cnt <= 3'd1;
         end else if (shift_en) begin
            acc        <= acc_next;
            sub_cnt    <= sub_cnt + 3'd1;
            byte_ready <= (sub_cnt == 3'd7);
         end else if (clear) begin
            sub_cnt <= '0;
         end
      end
   end

   assign byte_out = acc;

endmodule

// File: rtl/sti_rx_pack.sv
// STI receive packer: frames serial bits into bytes, writes them to a 256-entry
// buffer and reports each frame as done (8/16/24/32 bits) or erroneous.
module sti_rx_pack
   import sti_rx_pack_pkg::*;
(
   input logic         clk,
   input logic         reset,
   sti_rx_pack_if.slave bus
);

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [CNT_W-1:0]  bit_cnt;
   logic              frame_open;
   logic              start;
   logic              shift_en;
   logic              clear;
   logic              byte_ready;
   logic [BYTE_W-1:0] byte_val;

   assign start    = (state == ST_IDLE)  &&  bus.si_valid;
   assign shift_en = (state == ST_SHIFT) &&  bus.si_valid;
   assign clear    = (state == ST_SHIFT) && !bus.si_valid;

   sti_rx_shifter u_shifter (
      .clk        (clk),
      .rst        (reset),
      .start      (start),
      .shift_en   (shift_en),
      .clear      (clear),
      .lsb_first  (bus.lsb_first),
      .bit_in     (bus.si_data),
      .byte_out   (byte_val),
      .byte_ready (byte_ready)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= ST_IDLE;
         ptr               <= '0;
         bit_cnt           <= '0;
         frame_open        <= 1'b0;
         bus.pixel_wr      <= 1'b0;
         bus.pixel_addr    <= '0;
         bus.pixel_dataout <= '0;
         bus.frame_done    <= 1'b0;
         bus.frame_err     <= 1'b0;
         bus.frame_bits    <= '0;
         bus.buf_full      <= 1'b0;
      end else begin
         bus.pixel_wr   <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.frame_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.si_valid) begin
                  state   <= ST_SHIFT;
                  bit_cnt <= CNT_W'(1);
               end
            end
            ST_SHIFT: begin
               if (bus.si_valid) begin
                  bit_cnt <= sat_inc(bit_cnt);
               end else begin
                  state          <= ST_IDLE;
                  bus.frame_bits <= bit_cnt;
                  bus.frame_done <=  is_legal_len(bit_cnt);
                  bus.frame_err  <= !is_legal_len(bit_cnt);
               end
            end
            ST_FULL: begin
               // Only the frame caught in flight at the 255 write still gets its status.
               if (frame_open) begin
                  if (bus.si_valid) begin
                     bit_cnt <= sat_inc(bit_cnt);
                  end else begin
                     frame_open     <= 1'b0;
                     bus.frame_bits <= bit_cnt;
                     bus.frame_done <=  is_legal_len(bit_cnt);
                     bus.frame_err  <= !is_legal_len(bit_cnt);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (byte_ready && !bus.buf_full) begin
            bus.pixel_wr      <= 1'b1;
            bus.pixel_addr    <= ptr;
            bus.pixel_dataout <= byte_val;
            if (ptr == '1) begin
               bus.buf_full <= 1'b1;
               state        <= ST_FULL;
               frame_open   <= bus.si_valid;
            end else begin
               ptr <= ptr + ADDR_W'(1);
            end
         end
      end
   end

   assign bus.state = state;

endmodule
